// File: rtl/dec_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : dec_ex_pipe_reg
// Description : Dual-slot decode->execute pipeline register. This is the only
//               source of the bundle that the execute stage consumes.
//               - Holds the issued pair while execute (or the global pipeline)
//                 stalls.
//               - A 1-entry skid buffer catches a pair that decode launched in
//                 the same cycle the stall appeared.
//               - Flush replaces the held pair, the skid entry and any incoming
//                 pair with NOOP bubbles.
//               - Saturating counters record stall cycles and issued-bubble
//                 cycles.
// Ports       : clk, rst                      clock / sync active-high reset
//               controlInDecode*/dataInDecode* slot 1/2 pair from decode
//               controlInDecodeValid           decode presents a pair
//               controlOutDecodeReady          registered; 1 = skid empty
//               controlInExecuteStall, stall   hold sources
//               flush                          discard every pending pair
//               controlOutDecEx*/dataOutDecEx* slot 1/2 pair to execute
//               controlOutStallCnt             saturating hold-cycle count
//               controlOutBubbleCnt            saturating bubble-issue count
// Revision    : 1.0  initial release
// ============================================================================
module dec_ex_pipe_reg #(
    parameter logic [4:0] NOOP_OP = 5'b00011,
    parameter logic [3:0] COND_AL = 4'hE,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    // slot 1 from decode
    input  logic [4:0]       controlInDecodeOp1,
    input  logic [39:0]      dataInDecodeRm1,
    input  logic [39:0]      dataInDecodeRn1,
    input  logic [39:0]      dataInDecodeRo1,
    input  logic [3:0]       controlInDecodeCond1,
    // slot 2 from decode
    input  logic [4:0]       controlInDecodeOp2,
    input  logic [39:0]      dataInDecodeRm2,
    input  logic [39:0]      dataInDecodeRn2,
    input  logic [39:0]      dataInDecodeRo2,
    input  logic [3:0]       controlInDecodeCond2,
    // handshake / pipeline control
    input  logic             controlInDecodeValid,
    output logic             controlOutDecodeReady,
    input  logic             controlInExecuteStall,
    input  logic             stall,
    input  logic             flush,
    // slot 1 to execute
    output logic [4:0]       controlOutDecExOp1,
    output logic [39:0]      dataOutDecExRm1,
    output logic [39:0]      dataOutDecExRn1,
    output logic [39:0]      dataOutDecExRo1,
    output logic [3:0]       controlOutDecExCond1,
    // slot 2 to execute
    output logic [4:0]       controlOutDecExOp2,
    output logic [39:0]      dataOutDecExRm2,
    output logic [39:0]      dataOutDecExRn2,
    output logic [39:0]      dataOutDecExRo2,
    output logic [3:0]       controlOutDecExCond2,
    // performance counters
    output logic [CNT_W-1:0] controlOutStallCnt,
    output logic [CNT_W-1:0] controlOutBubbleCnt
);

    // ------------------------------------------------------------------------
    // Pair representation: both slots always travel together as one word so
    // that slots can never split or reorder.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  op;
        logic [39:0] rm;
        logic [39:0] rn;
        logic [39:0] ro;
        logic [3:0]  cond;
    } slot_t;

    typedef struct packed {
        slot_t s1;
        slot_t s2;
    } pair_t;

    localparam slot_t            c_NOOP_SLOT = {NOOP_OP, 40'd0, 40'd0, 40'd0, COND_AL};
    localparam pair_t            c_NOOP_PAIR = {c_NOOP_SLOT, c_NOOP_SLOT};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    pair_t            r_main;
    pair_t            r_skid;
    logic             r_skidFull;
    logic             r_ready;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_bubbleCnt;

    // ------------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------------
    pair_t w_decPair;
    pair_t w_mainNext;
    pair_t w_skidNext;
    logic  w_skidFullNext;
    logic  w_hold;
    logic  w_accept;
    logic  w_nextIsBubble;
    logic  w_stallInc;
    logic  w_bubbleInc;

    assign w_decPair.s1 = {controlInDecodeOp1, dataInDecodeRm1, dataInDecodeRn1,
                           dataInDecodeRo1, controlInDecodeCond1};
    assign w_decPair.s2 = {controlInDecodeOp2, dataInDecodeRm2, dataInDecodeRn2,
                           dataInDecodeRo2, controlInDecodeCond2};

    assign w_hold   = controlInExecuteStall | stall;
    // Ready is only high while the skid is empty, so an accepted pair always
    // has somewhere to go even if a hold starts in the same cycle.
    assign w_accept = controlInDecodeValid & r_ready;

    always_comb begin
        w_mainNext     = r_main;
        w_skidNext     = r_skid;
        w_skidFullNext = r_skidFull;
        if (flush) begin
            // Flush beats hold: execute is expected to abandon its op.
            w_mainNext     = c_NOOP_PAIR;
            w_skidFullNext = 1'b0;
        end else if (w_hold) begin
            // Main is frozen; a pair launched at stall onset parks in the skid.
            if (w_accept) begin
                w_skidNext     = w_decPair;
                w_skidFullNext = 1'b1;
            end
        end else if (r_skidFull) begin
            // The parked pair is older than anything decode offers now.
            w_mainNext     = r_skid;
            w_skidFullNext = 1'b0;
        end else if (w_accept) begin
            w_mainNext = w_decPair;
        end else begin
            w_mainNext = c_NOOP_PAIR;
        end
    end

    assign w_nextIsBubble = (w_mainNext.s1.op == NOOP_OP) && (w_mainNext.s2.op == NOOP_OP);
    assign w_stallInc     = w_hold & ~flush;
    assign w_bubbleInc    = ~w_hold & w_nextIsBubble;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main      <= c_NOOP_PAIR;
            r_skid      <= c_NOOP_PAIR;
            r_skidFull  <= 1'b0;
            r_ready     <= 1'b1;
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else begin
            r_main     <= w_mainNext;
            r_skid     <= w_skidNext;
            r_skidFull <= w_skidFullNext;
            r_ready    <= ~w_skidFullNext;
            if (w_stallInc && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + c_CNT_ONE;
            end
            if (w_bubbleInc && (r_bubbleCnt != c_CNT_MAX)) begin
                r_bubbleCnt <= r_bubbleCnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign controlOutDecodeReady = r_ready;

    assign controlOutDecExOp1   = r_main.s1.op;
    assign dataOutDecExRm1      = r_main.s1.rm;
    assign dataOutDecExRn1      = r_main.s1.rn;
    assign dataOutDecExRo1      = r_main.s1.ro;
    assign controlOutDecExCond1 = r_main.s1.cond;

    assign controlOutDecExOp2   = r_main.s2.op;
    assign dataOutDecExRm2      = r_main.s2.rm;
    assign dataOutDecExRn2      = r_main.s2.rn;
    assign dataOutDecExRo2      = r_main.s2.ro;
    assign controlOutDecExCond2 = r_main.s2.cond;

    assign controlOutStallCnt  = r_stallCnt;
    assign controlOutBubbleCnt = r_bubbleCnt;

endmodule
`default_nettype wire

// File: tb/tb_dec_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_ex_pipe_reg
// Description : Self-checking bench for dec_ex_pipe_reg. A behavioural
//               reference pushes the expected registered state into a queue
//               whenever a cycle of stimulus is driven; the entry is popped
//               and compared after the clock edge. Directed checks against
//               literal values cover the headline scenarios.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dec_ex_pipe_reg;

    localparam logic [4:0] c_NOOP = 5'b00011;
    localparam logic [3:0] c_AL   = 4'hE;

    typedef struct packed {
        logic [4:0]  op;
        logic [39:0] rm;
        logic [39:0] rn;
        logic [39:0] ro;
        logic [3:0]  cond;
    } slot_t;

    typedef struct packed {
        slot_t s1;
        slot_t s2;
    } pair_t;

    typedef struct packed {
        pair_t       main;
        logic        ready;
        logic [15:0] sc;
        logic [15:0] bc;
    } exp_t;

    localparam pair_t c_NOOP_PAIR = {c_NOOP, 40'd0, 40'd0, 40'd0, c_AL,
                                     c_NOOP, 40'd0, 40'd0, 40'd0, c_AL};

    logic  clk = 1'b0;
    logic  rst;
    logic  valid;
    logic  exStall;
    logic  gStall;
    logic  flush;
    pair_t inPair;

    logic        ready;
    logic [15:0] stallCnt;
    logic [15:0] bubbleCnt;
    pair_t       obs;

    always #5 clk = ~clk;

    dec_ex_pipe_reg #(
        .NOOP_OP (5'b00011),
        .COND_AL (4'hE),
        .CNT_W   (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .controlInDecodeOp1    (inPair.s1.op),
        .dataInDecodeRm1       (inPair.s1.rm),
        .dataInDecodeRn1       (inPair.s1.rn),
        .dataInDecodeRo1       (inPair.s1.ro),
        .controlInDecodeCond1  (inPair.s1.cond),
        .controlInDecodeOp2    (inPair.s2.op),
        .dataInDecodeRm2       (inPair.s2.rm),
        .dataInDecodeRn2       (inPair.s2.rn),
        .dataInDecodeRo2       (inPair.s2.ro),
        .controlInDecodeCond2  (inPair.s2.cond),
        .controlInDecodeValid  (valid),
        .controlOutDecodeReady (ready),
        .controlInExecuteStall (exStall),
        .stall                 (gStall),
        .flush                 (flush),
        .controlOutDecExOp1    (obs.s1.op),
        .dataOutDecExRm1       (obs.s1.rm),
        .dataOutDecExRn1       (obs.s1.rn),
        .dataOutDecExRo1       (obs.s1.ro),
        .controlOutDecExCond1  (obs.s1.cond),
        .controlOutDecExOp2    (obs.s2.op),
        .dataOutDecExRm2       (obs.s2.rm),
        .dataOutDecExRn2       (obs.s2.rn),
        .dataOutDecExRo2       (obs.s2.ro),
        .controlOutDecExCond2  (obs.s2.cond),
        .controlOutStallCnt    (stallCnt),
        .controlOutBubbleCnt   (bubbleCnt)
    );

    int nAssert = 0;
    int nFail   = 0;

    // reference model state
    pair_t       mMain;
    pair_t       mSkid;
    logic        mSkidFull;
    logic        mReady;
    logic [15:0] mStall;
    logic [15:0] mBubble;
    exp_t        q[$];

    task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
        nAssert++;
        assert (o === e) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic pair_t mk(input logic [4:0] op1, input logic [39:0] rm1,
                                 input logic [4:0] op2, input logic [39:0] base);
        pair_t p;
        p.s1 = {op1, rm1, base + 40'h11, base + 40'h2, 4'h1};
        p.s2 = {op2, base + 40'h100, base + 40'h200, base + 40'h1, 4'h5};
        return p;
    endfunction

    // One clock of stimulus: advance the reference, queue its prediction,
    // clock the DUT, then pop and (optionally) compare.
    task automatic step(input bit doCheck);
        logic h;
        logic acc;
        exp_t e;
        h   = exStall | gStall;
        acc = valid & mReady;
        if (rst) begin
            mMain = c_NOOP_PAIR; mSkidFull = 1'b0; mReady = 1'b1;
            mStall = '0; mBubble = '0;
        end else begin
            if (h && !flush && mStall != 16'hFFFF) mStall = mStall + 16'd1;
            if (flush) begin
                mMain = c_NOOP_PAIR;
                mSkidFull = 1'b0;
            end else if (h) begin
                if (acc) begin
                    mSkid = inPair;
                    mSkidFull = 1'b1;
                end
            end else if (mSkidFull) begin
                mMain = mSkid;
                mSkidFull = 1'b0;
            end else if (acc) begin
                mMain = inPair;
            end else begin
                mMain = c_NOOP_PAIR;
            end
            if (!h && mMain.s1.op == c_NOOP && mMain.s2.op == c_NOOP && mBubble != 16'hFFFF)
                mBubble = mBubble + 16'd1;
            mReady = ~mSkidFull;
        end
        q.push_back({mMain, mReady, mStall, mBubble});
        @(posedge clk);
        #1;
        e = q.pop_front();
        if (doCheck) begin
            chk("pair",      obs,       e.main);
            chk("ready",     ready,     e.ready);
            chk("stallCnt",  stallCnt,  e.sc);
            chk("bubbleCnt", bubbleCnt, e.bc);
        end
    endtask

    pair_t pA;
    pair_t pB;

    initial begin
        rst = 1'b1; valid = 1'b0; exStall = 1'b0; gStall = 1'b0; flush = 1'b0;
        inPair = c_NOOP_PAIR;
        mMain = c_NOOP_PAIR; mSkid = c_NOOP_PAIR; mSkidFull = 1'b0; mReady = 1'b1;
        mStall = '0; mBubble = '0;
        pA = mk(5'h0A, 40'hA0_0000_0001, 5'h0B, 40'hAA00);
        pB = mk(5'h14, 40'hB0_0000_0002, 5'h15, 40'hBB00);

        // Reset state
        step(1);
        step(1);
        chk("reset_op1",   obs.s1.op,   c_NOOP);
        chk("reset_cond2", obs.s2.cond, c_AL);
        chk("reset_ready", ready,       1'b1);

        // 1: single pair, one-cycle latency
        rst = 1'b0;
        valid = 1'b1;
        inPair = mk(5'h01, 40'h5, 5'h02, 40'h300);
        step(1);
        chk("t1_op1",   obs.s1.op, 5'h01);
        chk("t1_rm1",   obs.s1.rm, 40'h5);
        chk("t1_ready", ready,     1'b1);

        // 2: stall onset with B launched -> B parks in skid, A held
        inPair = pA; step(1);
        chk("t2_A_op2", obs.s2.op, 5'h0B);
        inPair = pB; exStall = 1'b1; step(1);
        valid = 1'b0; inPair = c_NOOP_PAIR;
        step(1);
        step(1);
        chk("t2_A_held", obs,   pA);
        chk("t2_notrdy", ready, 1'b0);
        exStall = 1'b0; step(1);
        chk("t2_B_out", obs,   pB);
        chk("t2_rdy",   ready, 1'b1);
        step(1);

        // 3: skid full, flush together with stall -> NOOP, B never issued
        valid = 1'b1; inPair = pA; step(1);
        inPair = pB; exStall = 1'b1; step(1);
        valid = 1'b0; inPair = c_NOOP_PAIR; exStall = 1'b0; gStall = 1'b1; step(1);
        flush = 1'b1; step(1);
        chk("t3_noop",  obs,   c_NOOP_PAIR);
        chk("t3_ready", ready, 1'b1);
        flush = 1'b0; gStall = 1'b0;
        step(1);
        step(1);
        chk("t3_noB", obs, c_NOOP_PAIR);

        // 4: five idle unstalled cycles from reset -> BubbleCnt = 5
        rst = 1'b1; step(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1);
        chk("t4_bubble", bubbleCnt, 16'd5);

        // 5: StallCnt saturates at all-ones
        exStall = 1'b1;
        for (int i = 0; i < 65540; i++) step(0);
        step(1);
        step(1);
        chk("t5_sat", stallCnt, 16'hFFFF);
        exStall = 1'b0;

        // 6: reset while the skid is full
        valid = 1'b1; inPair = pA; step(1);
        inPair = pB; exStall = 1'b1; step(1);
        chk("t6_skid_full", ready, 1'b0);
        rst = 1'b1; step(1);
        chk("t6_pair",   obs,       c_NOOP_PAIR);
        chk("t6_ready",  ready,     1'b1);
        chk("t6_stall",  stallCnt,  16'd0);
        chk("t6_bubble", bubbleCnt, 16'd0);
        rst = 1'b0; exStall = 1'b0; valid = 1'b0;
        step(1);
        chk("t6_noB", obs, c_NOOP_PAIR);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
